order_delete_encoder: RTL and testbench

//  Transmit-side counterpart of the Order Delete parser. Serializes one Order Delete record
//  (timestamp, order ID, order book ID, side) into the packed little-endian 64-bit ITCH word stream.

---
 rtl/order_delete_encoder_if.sv | 30 +++
 rtl/order_delete_encoder.sv | 153 +++++++++++++++
 tb/tb_order_delete_encoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/order_delete_encoder_if.sv
// order_delete_encoder_if
//   Groups the record-input handshake, flush request, stream-output handshake
//   and status outputs of order_delete_encoder.
//   master : record source / stream sink (drives record fields, flush, out_ready)
//   slave  : the encoder (drives in_ready, out_data/keep/valid, tracker_out, msg_done)
interface order_delete_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] time_stamp;
    logic [63:0] order_id;
    logic [31:0] order_book_id;
    logic [7:0]  side;
    logic        flush;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  tracker_out;
    logic        msg_done;

    modport master (
        output in_valid, time_stamp, order_id, order_book_id, side, flush, out_ready,
        input  in_ready, out_data, out_keep, out_valid, tracker_out, msg_done
    );

    modport slave (
        input  in_valid, time_stamp, order_id, order_book_id, side, flush, out_ready,
        output in_ready, out_data, out_keep, out_valid, tracker_out, msg_done
    );
endinterface

// File: rtl/order_delete_encoder.sv
// order_delete_encoder
//   Serializes one Order Delete record (timestamp, order ID, order book ID,
//   side) into a byte-packed little-endian 64-bit ITCH word stream. Records
//   are packed back to back; a partial trailing word stays in the buffer as a
//   residual and is merged with the next record or emitted on flush.
// Ports
//   clk, rst       : clock; synchronous active-high reset
//   bus (slave)    : in_valid/in_ready record handshake with time_stamp,
//                    order_id, order_book_id, side; flush level request;
//                    out_data/out_keep/out_valid/out_ready stream output;
//                    tracker_out = 8 * residual bytes; msg_done pulse
// Configuration
//   ORDER_DELETE_TYPE_EN : when defined, the TYPE_CODE byte precedes the
//                          record (18-byte message instead of 17).
module order_delete_encoder
`ifdef ORDER_DELETE_TYPE_EN
#(
    parameter logic [7:0] TYPE_CODE = 8'h44
)
`endif
(
    input logic                   clk,
    input logic                   rst,
    order_delete_encoder_if.slave bus
);

`ifdef ORDER_DELETE_TYPE_EN
    localparam int unsigned MSG_LEN = 18;
`else
    localparam int unsigned MSG_LEN = 17;
`endif
    localparam int unsigned MSG_BITS = 8 * MSG_LEN;

    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [255:0]         r_buf;
    logic [4:0]           r_count;
    logic [2:0]           r_resid;
    logic [5:0]           r_tracker;
    logic                 r_msg_done;

    logic [MSG_BITS-1:0]  w_msg;
    logic [7:0]           w_lane_base;
    logic [4:0]           w_count_after;
    logic [7:0]           w_flush_keep;
    logic                 w_accept;
    logic                 w_out_hs;
    logic                 w_leave_send;

    // Lane 0 (earliest byte) sits in the least significant bits.
`ifdef ORDER_DELETE_TYPE_EN
    assign w_msg = {bus.side, bus.order_book_id, bus.order_id, bus.time_stamp, TYPE_CODE};
`else
    assign w_msg = {bus.side, bus.order_book_id, bus.order_id, bus.time_stamp};
`endif

    assign w_lane_base   = {2'b00, r_resid, 3'b000};
    assign w_flush_keep  = (8'h01 << r_resid) - 8'h01;
    assign w_accept      = bus.in_ready && bus.in_valid;
    assign w_out_hs      = bus.out_valid && bus.out_ready;
    assign w_count_after = w_out_hs ? (r_count - 5'd8) : r_count;
    // Leaving on the post-handshake count lets the last full word go straight
    // back to IDLE, so back-to-back records only lose the IDLE accept cycle.
    assign w_leave_send  = (r_state == SEND) && (w_count_after < 5'd8);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; a record beats a simultaneous flush
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid)                       w_state_next = SEND;
                else if (bus.flush && (r_resid != '0))  w_state_next = FLUSH;
            end
            SEND:    if (w_leave_send)  w_state_next = IDLE;
            FLUSH:   if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode from registered state and buffer
    always_comb begin
        bus.in_ready    = (r_state == IDLE) && !rst;
        bus.out_valid   = 1'b0;
        bus.out_keep    = '0;
        bus.out_data    = '0;
        bus.tracker_out = r_tracker;
        bus.msg_done    = r_msg_done;
        case (r_state)
            SEND: begin
                bus.out_valid = (r_count >= 5'd8);
                bus.out_keep  = bus.out_valid ? 8'hFF : 8'h00;
                bus.out_data  = r_buf[63:0];
            end
            FLUSH: begin
                bus.out_valid = 1'b1;
                bus.out_keep  = w_flush_keep;
                for (int unsigned i = 0; i < 8; i++)
                    bus.out_data[8*i +: 8] = w_flush_keep[i] ? r_buf[8*i +: 8] : 8'h00;
            end
            default: ;
        endcase
    end

    // Byte buffer, counts and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf      <= '0;
            r_count    <= '0;
            r_resid    <= '0;
            r_tracker  <= '0;
            r_msg_done <= 1'b0;
        end else begin
            r_msg_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_buf[w_lane_base +: MSG_BITS] <= w_msg;
                        r_count <= {2'b00, r_resid} + 5'(MSG_LEN);
                    end
                end
                SEND: begin
                    if (w_out_hs) begin
                        r_buf   <= r_buf >> 64;
                        r_count <= r_count - 5'd8;
                    end
                    if (w_leave_send) begin
                        r_resid    <= w_count_after[2:0];
                        r_tracker  <= {w_count_after[2:0], 3'b000};
                        r_msg_done <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (bus.out_ready) begin
                        r_buf     <= '0;
                        r_count   <= '0;
                        r_resid   <= '0;
                        r_tracker <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_order_delete_encoder.sv
module tb_order_delete_encoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    order_delete_encoder_if dut_if ();

    order_delete_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [71:0] exp_q[$];   // {data, keep}
    logic [63:0] got_q[$];   // every word the DUT hands over
    logic [7:0]  mq[$];      // model residual bytes, lane 0 first

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stream monitor / scoreboard
    always @(negedge clk) begin
        logic [71:0] e;
        if (!rst && dut_if.out_valid && dut_if.out_ready) begin
            got_q.push_back(dut_if.out_data);
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(exp_q.size()), 64'(1));
            end else begin
                e = exp_q.pop_front();
                check("word_data", dut_if.out_data, e[71:8]);
                check("word_keep", 64'(dut_if.out_keep), 64'(e[7:0]));
            end
        end
    end

    task automatic model_push(input logic [31:0] ts, input logic [63:0] oid,
                              input logic [31:0] obid, input logic [7:0] sd);
        logic [63:0] w;
`ifdef ORDER_DELETE_TYPE_EN
        mq.push_back(8'h44);
`endif
        for (int i = 0; i < 4; i++) mq.push_back(ts[8*i +: 8]);
        for (int i = 0; i < 8; i++) mq.push_back(oid[8*i +: 8]);
        for (int i = 0; i < 4; i++) mq.push_back(obid[8*i +: 8]);
        mq.push_back(sd);
        while (mq.size() >= 8) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = mq.pop_front();
            exp_q.push_back({w, 8'hFF});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic drive_record(input logic [31:0] ts, input logic [63:0] oid,
                                input logic [31:0] obid, input logic [7:0] sd);
        logic acc;
        int   n;
        dut_if.time_stamp    = ts;
        dut_if.order_id      = oid;
        dut_if.order_book_id = obid;
        dut_if.side          = sd;
        dut_if.in_valid      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = dut_if.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        dut_if.in_valid = 1'b0;
        if (!acc) check("accept_timeout", 64'(acc), 64'(1));
        else      model_push(ts, oid, obid, sd);
    endtask

    task automatic wait_done(input bit rnd_ready);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dut_if.msg_done) begin
                seen = 1;
                check("tracker_out", 64'(dut_if.tracker_out), 64'(8 * mq.size()));
                break;
            end
            @(posedge clk);
            #1;
            if (rnd_ready) dut_if.out_ready = 1'($urandom_range(0, 1));
        end
        check("msg_done_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        dut_if.out_ready = 1'b1;
    endtask

    task automatic do_flush();
        logic [63:0] w;
        logic [7:0]  k;
        int          n;
        if (mq.size() > 0) begin
            w = '0;
            n = mq.size();
            for (int i = 0; i < n; i++) w[8*i +: 8] = mq.pop_front();
            k = 8'((9'h001 << n) - 9'h001);
            exp_q.push_back({w, k});
        end
        dut_if.out_ready = 1'b1;
        dut_if.flush     = 1'b1;
        @(posedge clk);
        #1;
        dut_if.flush = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("flush_tracker", 64'(dut_if.tracker_out), 64'(0));
        check("flush_drained", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        dut_if.in_valid      = 1'b0;
        dut_if.flush         = 1'b0;
        dut_if.out_ready     = 1'b1;
        dut_if.time_stamp    = '0;
        dut_if.order_id      = '0;
        dut_if.order_book_id = '0;
        dut_if.side          = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(dut_if.in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(dut_if.out_valid), 64'(0));
        check("rst_out_data", dut_if.out_data, 64'(0));
        check("rst_out_keep", 64'(dut_if.out_keep), 64'(0));
        check("rst_tracker", 64'(dut_if.tracker_out), 64'(0));
        check("rst_msg_done", 64'(dut_if.msg_done), 64'(0));
        check("idle_in_ready", 64'(dut_if.in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Single record at lane 0
        got_q.delete();
        drive_record(32'h11223344, 64'h0102030405060708, 32'hAABBCCDD, 8'h42);
        wait_done(0);
`ifdef ORDER_DELETE_TYPE_EN
        check("t6_word0", got_q[0], 64'h0607081122334444);
        check("t6_word1", got_q[1], 64'hBBCCDD0102030405);
        check("t6_tracker", 64'(dut_if.tracker_out), 64'(16));
`else
        check("t1_word0", got_q[0], 64'h0506070811223344);
        check("t1_word1", got_q[1], 64'hAABBCCDD01020304);
        check("t1_tracker", 64'(dut_if.tracker_out), 64'(8));
`endif

        // Same record merged behind the residual
        got_q.delete();
        drive_record(32'h11223344, 64'h0102030405060708, 32'hAABBCCDD, 8'h42);
        wait_done(0);
`ifndef ORDER_DELETE_TYPE_EN
        check("t2_word0", got_q[0], 64'h0607081122334442);
        check("t2_words", 64'(got_q.size()), 64'(2));
        check("t2_tracker", 64'(dut_if.tracker_out), 64'(16));
`endif
        do_flush();

        // Flush of a single-record residual, then a flush with nothing held
        drive_record(32'h11223344, 64'h0102030405060708, 32'hAABBCCDD, 8'h42);
        wait_done(0);
        got_q.delete();
        do_flush();
`ifndef ORDER_DELETE_TYPE_EN
        check("t3_flush_word", got_q[0], 64'h42);
`endif
        got_q.delete();
        do_flush();
        check("t3_noop_flush", 64'(got_q.size()), 64'(0));

        // Downstream stall while a full word is presented
        dut_if.out_ready = 1'b0;
        drive_record(32'hCAFEF00D, 64'h1122334455667788, 32'h99AABBCC, 8'h53);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(dut_if.out_valid), 64'(1));
            check("stall_data", dut_if.out_data, exp_q[0][71:8]);
            @(posedge clk);
            #1;
        end
        dut_if.out_ready = 1'b1;
        wait_done(0);

        // Reset while the second word is pending
        drive_record(32'h01010101, 64'h0202020202020202, 32'h03030303, 8'h04);
        @(posedge clk);
        #1;
        dut_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(dut_if.in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mq.delete();
        @(negedge clk);
        check("post_rst_valid", 64'(dut_if.out_valid), 64'(0));
        check("post_rst_tracker", 64'(dut_if.tracker_out), 64'(0));
        @(posedge clk);
        #1;
        dut_if.out_ready = 1'b1;
        got_q.delete();
        drive_record(32'h11223344, 64'h0102030405060708, 32'hAABBCCDD, 8'h42);
        wait_done(0);
`ifndef ORDER_DELETE_TYPE_EN
        check("t5_lane0_word", got_q[0], 64'h0506070811223344);
`endif

        // Random records with random backpressure and occasional flushes
        for (int r = 0; r < 24; r++) begin
            drive_record($urandom, {$urandom, $urandom}, $urandom, 8'($urandom));
            wait_done(1);
            if ($urandom_range(0, 3) == 0) do_flush();
        end
        do_flush();
        check("final_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
